// File: rtl/dcache_2way_top.sv
// rtl/dcache_2way_top.sv - 2-way set-associative write-back data cache, 32-byte lines, LRU replacement
// Optional DCACHE_PERF_EN adds access and miss counters (acc_cnt_o, miss_cnt_o).
module dcache_2way_top #(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 27 - INDEX_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [255:0]  mem_data_i,
  input  logic          mem_ack_i,
  output logic [255:0]  mem_data_o,
  output logic [31:0]   mem_addr_o,
  output logic          mem_enable_o,
  output logic          mem_write_o,
  input  logic [31:0]   p1_data_i,
  input  logic [31:0]   p1_addr_i,
  input  logic          p1_MemRead_i,
  input  logic          p1_MemWrite_i,
  output logic [31:0]   p1_data_o,
  output logic          p1_stall_o
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]   acc_cnt_o,
  output logic [31:0]   miss_cnt_o
`endif
);

  localparam int SETS = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WRITEBACK,
    S_REFILL,
    S_REFILL_DONE
  } state_t;

  state_t state;

  logic [1:0][SETS-1:0] valid_q;
  logic [1:0][SETS-1:0] dirty_q;
  logic [SETS-1:0]      lru_q;
  logic [TAG_W-1:0]     tag_q  [2][SETS];
  logic [255:0]         line_q [2][SETS];
  logic                 victim_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   ptag;
  logic [7:0]         woff;
  logic               hit0, hit1, hit, hit_way, req, idle_hit, victim_c;
  logic               unused_addr_bits;

  assign idx      = p1_addr_i[5+INDEX_W-1:5];
  assign ptag     = p1_addr_i[31:5+INDEX_W];
  assign woff     = {p1_addr_i[4:2], 5'd0};
  assign unused_addr_bits = ^p1_addr_i[1:0];

  assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == ptag);
  assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == ptag);
  assign hit      = hit0 || hit1;
  assign hit_way  = hit1;
  assign req      = p1_MemRead_i || p1_MemWrite_i;
  assign idle_hit = (state == S_IDLE) && hit;

  // Prefer an empty way (way 0 first); otherwise replace the least-recently-used way.
  assign victim_c = !valid_q[0][idx] ? 1'b0 :
                    !valid_q[1][idx] ? 1'b1 : lru_q[idx];

  assign p1_stall_o = req && !idle_hit;
  assign p1_data_o  = (p1_MemRead_i && !p1_MemWrite_i && idle_hit)
                      ? line_q[hit_way][idx][woff +: 32] : 32'd0;

  // Miss-handling FSM with registered memory interface; also performs hit updates and line fills.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= S_IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      lru_q        <= '0;
      victim_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req && hit) begin
            lru_q[idx] <= ~hit_way;
            if (p1_MemWrite_i) begin
              line_q[hit_way][idx][woff +: 32] <= p1_data_i;
              dirty_q[hit_way][idx]            <= 1'b1;
            end
          end else if (req) begin
            state <= S_MISS;
          end
        end
        S_MISS: begin
          victim_q     <= victim_c;
          mem_enable_o <= 1'b1;
          if (valid_q[victim_c][idx] && dirty_q[victim_c][idx]) begin
            state       <= S_WRITEBACK;
            mem_write_o <= 1'b1;
            mem_addr_o  <= {tag_q[victim_c][idx], idx, 5'b0};
            mem_data_o  <= line_q[victim_c][idx];
          end else begin
            state       <= S_REFILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {ptag, idx, 5'b0};
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) begin
            state       <= S_REFILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {ptag, idx, 5'b0};
          end
        end
        S_REFILL: begin
          if (mem_ack_i) begin
            state                  <= S_REFILL_DONE;
            mem_enable_o           <= 1'b0;
            line_q[victim_q][idx]  <= mem_data_i;
            tag_q[victim_q][idx]   <= ptag;
            valid_q[victim_q][idx] <= 1'b1;
            dirty_q[victim_q][idx] <= 1'b0;
          end
        end
        S_REFILL_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state        <= S_IDLE;
          mem_enable_o <= 1'b0;
          mem_write_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCACHE_PERF_EN
  // Count completed accesses and misses entering the miss path.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (req && !p1_stall_o) acc_cnt_o <= acc_cnt_o + 32'd1;
      if (state == S_IDLE && req && !hit) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_2way_top.sv
// tb/tb_dcache_2way_top.sv - randomized model-checked bench for dcache_2way_top
module tb_dcache_2way_top;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  p1_data_i;
  logic [31:0]  p1_addr_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
`ifdef DCACHE_PERF_EN
  logic [31:0]  acc_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  dcache_2way_top dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i),
    .mem_data_o   (mem_data_o),
    .mem_addr_o   (mem_addr_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .p1_data_i    (p1_data_i),
    .p1_addr_i    (p1_addr_i),
    .p1_MemRead_i (p1_MemRead_i),
    .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o)
`ifdef DCACHE_PERF_EN
    ,
    .acc_cnt_o    (acc_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: resident line addresses per set/way, recency, and a backing memory.
  bit           m_valid [2][32];
  bit           m_dirty [2][32];
  logic [31:0]  m_la    [2][32];
  logic [255:0] m_line  [2][32];
  bit           m_lru   [32];
  int           m_acc;
  int           m_miss;
  logic [255:0] backing [logic [31:0]];

  bit           last_hit;
  logic [31:0]  last_rdata;
  int           last_nreq;
  logic [31:0]  last_wb_addr;
  logic [255:0] last_wb_data;
  logic [31:0]  last_rf_addr;

  function automatic logic [255:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] get_line(input logic [31:0] la);
    if (!backing.exists(la)) backing[la] = rand_line();
    return backing[la];
  endfunction

  task automatic m_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 32; s++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
      end
    for (int s = 0; s < 32; s++) m_lru[s] = 1'b0;
    m_acc  = 0;
    m_miss = 0;
  endtask

  function automatic int find_way(input logic [31:0] la);
    int s = int'(la[9:5]);
    for (int w = 0; w < 2; w++)
      if (m_valid[w][s] && m_la[w][s] == la) return w;
    return -1;
  endfunction

  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0]  la;
    int           s, wsel, w, vic, exp_n, nreq, delay, cyc;
    bit           serving, ack_clr, cap_wr;
    logic [31:0]  cap_addr;
    logic [255:0] cap_data;
    bit           exp_wr   [2];
    logic [31:0]  exp_addr [2];
    logic [255:0] exp_data [2];
    la   = {addr[31:5], 5'b0};
    s    = int'(addr[9:5]);
    wsel = int'(addr[4:2]);
    p1_addr_i = addr; p1_data_i = wdata; p1_MemRead_i = rd; p1_MemWrite_i = wr;
    w = find_way(la);
    last_hit = (w >= 0);
    nreq = 0; exp_n = 0; vic = 0;
    if (w < 0) begin
      vic = !m_valid[0][s] ? 0 : !m_valid[1][s] ? 1 : int'(m_lru[s]);
      if (m_valid[vic][s] && m_dirty[vic][s]) begin
        exp_wr[0] = 1'b1; exp_addr[0] = m_la[vic][s]; exp_data[0] = m_line[vic][s];
        exp_n = 1;
      end
      exp_wr[exp_n] = 1'b0; exp_addr[exp_n] = la; exp_data[exp_n] = '0;
      exp_n++;
    end
    @(negedge clk);
    if (w >= 0) begin
      check("hit_stall", p1_stall_o, 1'b0);
      check("hit_rdata", p1_data_o, wr ? 32'd0 : m_line[w][s][wsel*32 +: 32]);
      check("hit_no_mem", mem_enable_o, 1'b0);
    end else begin
      serving = 0; ack_clr = 0; delay = 0; cyc = 0;
      cap_wr = 0; cap_addr = '0; cap_data = '0;
      check("miss_stall", p1_stall_o, 1'b1);
      while (p1_stall_o && cyc < 80) begin
        mem_ack_i = 1'b0;
        if (ack_clr) begin ack_clr = 0; serving = 0; end
        check("stall_rdata_zero", p1_data_o, 32'd0);
        if (mem_enable_o) begin
          if (!serving) begin
            cap_wr = mem_write_o; cap_addr = mem_addr_o; cap_data = mem_data_o;
            if (nreq < exp_n) begin
              check("req_write", mem_write_o, exp_wr[nreq]);
              check("req_addr", mem_addr_o, exp_addr[nreq]);
              if (exp_wr[nreq]) check("req_wb_data", mem_data_o, exp_data[nreq]);
            end else begin
              check("req_extra", nreq, exp_n - 1);
            end
            if (mem_write_o) begin last_wb_addr = mem_addr_o; last_wb_data = mem_data_o; end
            else last_rf_addr = mem_addr_o;
            nreq++;
            serving = 1;
            delay = $urandom_range(0, 3);
          end else begin
            check("req_held", {mem_write_o, mem_addr_o}, {cap_wr, cap_addr});
            if (cap_wr) check("req_held_data", mem_data_o, cap_data);
          end
          if (delay == 0) begin
            mem_ack_i  = 1'b1;
            ack_clr    = 1;
            mem_data_i = cap_wr ? rand_line() : get_line(cap_addr);
          end else delay--;
        end else begin
          mem_ack_i  = ($urandom_range(0, 3) == 0);
          mem_data_i = rand_line();
        end
        @(negedge clk);
        cyc++;
      end
      mem_ack_i = 1'b0;
      check("miss_timeout", cyc < 80, 1'b1);
      check("miss_nreq", nreq, exp_n);
      check("miss_done_stall", p1_stall_o, 1'b0);
      if (exp_n == 2) backing[exp_addr[0]] = exp_data[0];
      m_valid[vic][s] = 1'b1;
      m_dirty[vic][s] = 1'b0;
      m_la[vic][s]    = la;
      m_line[vic][s]  = get_line(la);
      w = vic;
      check("miss_rdata", p1_data_o, wr ? 32'd0 : m_line[w][s][wsel*32 +: 32]);
      m_miss++;
    end
    last_rdata = p1_data_o;
    last_nreq  = nreq;
    if (wr) begin
      m_line[w][s][wsel*32 +: 32] = wdata;
      m_dirty[w][s] = 1'b1;
    end
    m_lru[s] = (w == 0);
    m_acc++;
    @(posedge clk); #1;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ack_i  = ($urandom_range(0, 3) == 0);
      mem_data_i = rand_line();
      @(negedge clk);
      check("idle_stall", p1_stall_o, 1'b0);
      check("idle_rdata", p1_data_o, 32'd0);
      check("idle_mem_en", mem_enable_o, 1'b0);
    end
    mem_ack_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    m_reset();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [255:0] l40;
    logic [31:0]  rnd_addr;
    int           kind, cyc;
    rst_i = 1'b0; mem_data_i = '0; mem_ack_i = 1'b0;
    p1_data_i = '0; p1_addr_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    m_reset();

    // Reset state: memory interface idle and every line invalid.
    repeat (2) @(posedge clk);
    #1 p1_addr_i = 32'h40; p1_MemRead_i = 1'b1;
    @(negedge clk);
    check("rst_mem_en", mem_enable_o, 1'b0);
    check("rst_mem_wr", mem_write_o, 1'b0);
    check("rst_miss_stall", p1_stall_o, 1'b1);
    check("rst_rdata", p1_data_o, 32'd0);
    p1_MemRead_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk); #1;

    // First load misses and refills from 0x40; word 1 of that line is 0xDEADBEEF.
    l40 = rand_line();
    l40[63:32] = 32'hDEADBEEF;
    backing[32'h40] = l40;
    do_access(1, 0, 32'h40, 0);
    check("lit_first_miss", last_hit, 1'b0);
    check("lit_refill_addr", last_rf_addr, 32'h40);
    check("lit_refill_nreq", last_nreq, 1);
    do_access(0, 1, 32'h40, 32'h12345678);
    check("lit_store_hit", last_hit, 1'b1);
`ifdef DCACHE_PERF_EN
    check("lit_acc_cnt", acc_cnt_o, 32'd2);
    check("lit_miss_cnt", miss_cnt_o, 32'd1);
`endif
    do_access(1, 0, 32'h44, 0);
    check("lit_load44", last_rdata, 32'hDEADBEEF);
    check("lit_load44_hit", last_hit, 1'b1);
    do_access(1, 0, 32'h40, 0);
    check("lit_load40", last_rdata, 32'h12345678);
    idle(2);

    // Fill both ways of set 2, then a third tag evicts the LRU way.
    do_access(1, 0, 32'h440, 0);
    check("lit_440_miss", last_hit, 1'b0);
    do_access(1, 0, 32'h040, 0);
    check("lit_040_hit", last_hit, 1'b1);
    do_access(1, 0, 32'h840, 0);
    check("lit_840_nreq", last_nreq, 1);
    do_access(1, 0, 32'h440, 0);
    check("lit_440_evicted", last_hit, 1'b0);
    check("lit_wb_nreq", last_nreq, 2);
    check("lit_wb_addr", last_wb_addr, 32'h40);
    check("lit_wb_word0", last_wb_data[31:0], 32'h12345678);
    check("lit_wb_word1", last_wb_data[63:32], 32'hDEADBEEF);
    check("lit_rf_addr", last_rf_addr, 32'h440);

    // Reset while a writeback is outstanding abandons it.
    do_access(0, 1, 32'h1000, 32'hA5A5A5A5);
    do_access(0, 1, 32'h2000, 32'h5A5A5A5A);
    p1_addr_i = 32'h3000; p1_MemRead_i = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!(mem_enable_o && mem_write_o) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("wb_reached", cyc < 20, 1'b1);
    check("wb_addr_before_rst", mem_addr_o, 32'h1000);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_mid_wb_en", mem_enable_o, 1'b0);
    check("rst_mid_wb_wr", mem_write_o, 1'b0);
    p1_MemRead_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    m_reset();
    do_access(1, 0, 32'h3000, 0);
    check("lit_post_rst_miss", last_hit, 1'b0);
    do_access(1, 0, 32'h1000, 0);
    check("lit_1000_invalid", last_hit, 1'b0);
    do_access(1, 0, 32'h1000, 0);
    check("lit_1000_hit", last_hit, 1'b1);

    // Randomized traffic over a few sets and tags to force conflicts and dirty evictions.
    for (int i = 0; i < 300; i++) begin
      rnd_addr = ($urandom_range(0, 1) << 31) | ($urandom_range(0, 3) << 10) |
                 ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) |
                 $urandom_range(0, 3);
      kind = $urandom_range(0, 2);
      do_access(kind != 1, kind != 0, rnd_addr, $urandom());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

`ifdef DCACHE_PERF_EN
    check("perf_acc_final", acc_cnt_o, m_acc);
    check("perf_miss_final", miss_cnt_o, m_miss);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_2way_top.md
DCACHE_2WAY_TOP -- requirements
Module: dcache_2way_top

Interface
REQ-001 Parameter: INDEX_W, 5, set-index width; the cache SHALL have 2^INDEX_W sets, 2 ways per set and 32-byte lines.
REQ-002 Parameter: TAG_W, 27-INDEX_W (derived), tag width taken from p1_addr_i[31:5+INDEX_W].
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-low.
REQ-005 mem_data_i  input  256  refill line from data memory.
REQ-006 mem_ack_i  input  1  memory completion pulse, one cycle.
REQ-007 mem_data_o  output  256  write-back line to memory.
REQ-008 mem_addr_o  output  32  line address; bits [4:0] always 0.
REQ-009 mem_enable_o  output  1  memory request, registered.
REQ-010 mem_write_o  output  1  1 = write-back, 0 = refill, registered.
REQ-011 p1_data_i  input  32  CPU store data.
REQ-012 p1_addr_i  input  32  CPU byte address; word select is [4:2]; bits [1:0] are ignored.
REQ-013 p1_MemRead_i  input  1  load request.
REQ-014 p1_MemWrite_i  input  1  store request; when both request inputs are high, the access SHALL be a store.
REQ-015 p1_data_o  output  32  load data, combinational.
REQ-016 p1_stall_o  output  1  combinational; equals request AND NOT (state==IDLE AND hit).

Function
REQ-017 Per way and set, storage SHALL hold a valid bit, a dirty bit, a tag and a 256-bit line; per set, storage SHALL hold one LRU bit naming the least-recently-used way.
REQ-018 Hit: valid AND tag match in either way, evaluated combinationally; both ways matching SHALL NOT occur by construction.
REQ-019 Load hit: p1_data_o SHALL show the selected 32-bit word in the same cycle, with stall low; the LRU bit SHALL point to the other way at the next edge.
REQ-020 Store hit: at the next edge, the selected word of the hit line SHALL take p1_data_i, dirty SHALL be set to 1 and LRU SHALL be updated; zero-stall.
REQ-021 Whenever no load hit is delivered, p1_data_o SHALL be 0.
REQ-022 States: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE.
REQ-023 IDLE->MISS on a request with no hit; the victim SHALL be captured in MISS as the invalid way (way 0 if both are invalid), else the LRU way.
REQ-024 MISS->WRITEBACK if the victim is valid and dirty; the block SHALL drive mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0} and mem_data_o=victim line.
REQ-025 MISS->REFILL otherwise; the block SHALL drive mem_enable_o=1, mem_write_o=0, mem_addr_o={p1 tag, index, 5'b0}.
REQ-026 WRITEBACK: mem outputs SHALL be held until mem_ack_i; on ack the next state is REFILL, with mem_write_o=0 and mem_enable_o=1 for the next cycle.
REQ-027 REFILL: on mem_ack_i the victim way SHALL be written with mem_data_i, valid=1, dirty=0 and the new tag; mem_enable_o SHALL be 0 from the next cycle; the next state is REFILL_DONE.
REQ-028 REFILL_DONE->IDLE unconditionally; the access SHALL then complete as a hit, so a store miss is a refill plus a store hit (write-allocate).
REQ-029 Any mem_ack_i seen in IDLE, MISS or REFILL_DONE SHALL be ignored.
REQ-030 CPU address and request inputs SHALL be held stable by the CPU while stall is high; behaviour under changed inputs is undefined.

Reset
REQ-031 With rst_i=0 at an edge: state=IDLE, mem_enable_o=0, mem_write_o=0, all valid, dirty and LRU bits 0; line data is not reset.
REQ-032 Reset mid-transaction SHALL abandon it; mem_enable_o SHALL be low from the first reset edge.

Configuration
REQ-033 With DCACHE_PERF_EN defined, the block SHALL add the outputs acc_cnt_o (32) and miss_cnt_o (32), both reset to 0.
REQ-034 acc_cnt_o SHALL increment on each cycle with request AND NOT stall; miss_cnt_o SHALL increment on each IDLE->MISS transition; both SHALL wrap modulo 2^32.
REQ-035 Without DCACHE_PERF_EN, the ports and counters SHALL be absent and behaviour is otherwise identical.

Verification
REQ-036 Reset, then load 0x0000_0040: stall high; REFILL request at addr 0x40 with mem_write_o=0; ack with word1=0xDEADBEEF; after REFILL_DONE, a load of 0x44 returns 0xDEADBEEF with no stall.
REQ-037 Store 0x1234_5678 to 0x40 (hit): zero stall; a following load of 0x40 returns 0x12345678 and the line is dirty.
REQ-038 Fill both ways of set 2 (addr 0x040, 0x440 with INDEX_W=5), then touch 0x040; a miss on 0x840 SHALL evict the 0x440 way (LRU).
REQ-039 Dirty-victim miss: WRITEBACK at the victim address with the stored data, then REFILL at the new address; exactly 2 memory requests.
REQ-040 Assert reset during WRITEBACK before ack: mem_enable_o=0 next cycle; a subsequent load to the same address misses (valid cleared).
REQ-041 With DCACHE_PERF_EN, for the sequence of REQ-036 and REQ-037: acc_cnt_o=2 (REQ-036's stalled load and the zero-stall store each counted once on completion), miss_cnt_o=1.
